life_step_engine: RTL and testbench
===================================

// Module: life_step_engine
// PURPOSE
//  Writer side of the cell-grid interface. Holds the live COLS x ROWS Game-of-Life grid and drives it flat to the display renderer.
//  - Cell (c,r) sits at bit c + r*COLS; 1 = alive.
//  - On request, computes one B3/S23 generation into a shadow buffer, one row per cycle.
//  - Commits the shadow buffer atomically on a frame-sync edge, so the renderer never shows a half-updated grid.
// PARAMETERS
//  COLS  80  grid width in cells
//  ROWS  48  grid height in cells
//  WRAP  1   1 = toroidal edges; 0 = cells outside the grid count as dead
// PORTS
//  clk         in   1          system clock, single clock domain
//  reset_n     in   1          asynchronous, active-low reset
//  step        in   1          request one generation; sampled only in IDLE
//  frame_sync  in   1          vertical sync level from the timing generator; commit on its rising edge
//  load_valid  in   1          load seed pattern; sampled only in IDLE
//  load_data   in   COLS*ROWS  seed pattern, same bit layout as grid
//  grid        out  COLS*ROWS  current committed generation, to the renderer
//  busy        out  1          high in COMPUTE, WAIT_SYNC and COMMIT
//  done        out  1          one-cycle pulse, same cycle grid takes the new generation
//  generation  out  16         committed-generation count; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, grid=0, shadow=0, row=0, generation=0, busy=0, done=0, fs_q=0.
//  fs_q registers frame_sync every cycle. fs_rise = frame_sync & ~fs_q.
//  FSM:
//   - IDLE: if load_valid: grid<=load_data, generation<=0, stay IDLE.
//     Else if step: row<=0, go to COMPUTE.
//     If load_valid and step arrive together, the load wins and the step is dropped.
//   - COMPUTE: shadow row[row] <= rule(grid rows row-1, row, row+1).
//     row increments each cycle. After row ROWS-1, go to WAIT_SYNC.
//     Takes exactly ROWS cycles.
//   - WAIT_SYNC: hold until fs_rise, then go to COMMIT.
//     If the edge coincides with the last COMPUTE cycle, it is not seen; wait for the next edge.
//   - COMMIT (1 cycle): grid<=shadow, generation+=1, done=1, go to IDLE.
//  step and load_valid are ignored outside IDLE; no queueing.
//  grid changes only on load (IDLE) or in COMMIT; it is stable throughout COMPUTE.
//  Rule: n = live neighbour sum, 4 bits, range 0..8.
//   - next = (n==3) | (alive & n==2).
//   - Neighbour indices use modulo COLS/ROWS when WRAP=1; out-of-range neighbours read 0 when WRAP=0.
//  Latency: step at cycle t gives COMPUTE t+1..t+ROWS; COMMIT on the cycle after the first fs_rise at or after t+ROWS+1.
//  Reset mid-operation: all partial shadow work is discarded; grid=0.
// STRUCTURE
//  Shared package life_pkg:
//   - COLS/ROWS defaults, CELLS = COLS*ROWS.
//   - function cell_idx(c,r) = c + r*COLS.
//   - state enum {IDLE, COMPUTE, WAIT_SYNC, COMMIT}.
//  Sub-module life_row_update (combinational):
//   - inputs: above, cur, below rows, each COLS bits, plus WRAP.
//   - output: next row, COLS bits. Instantiated once, muxed by row.
//  Top level holds the FSM, row counter, shadow buffer, fs_q and generation counter.
// TESTING
//  1. Blinker: load vertical 3 at (10,9..11); step; pulse frame_sync.
//     -> done once; grid has horizontal (9..11,10) only; generation=1.
//  2. Wrap glider: WRAP=1, glider at corner (78..79/0, 46..47/0); run 4 steps.
//     -> same shape shifted (+1,+1) mod grid. With WRAP=0, the corner cells die instead.
//  3. Sync gating: step, hold frame_sync low for 200 cycles.
//     -> busy=1 and grid unchanged for all 200 cycles; commit the cycle after the rising edge; done width = 1 cycle.
//  4. Ignored inputs: step pulse and load_valid during COMPUTE.
//     -> no effect; exactly one generation is committed.
//     Load and step together in IDLE -> grid=load_data, busy stays 0.
//  5. Reset mid-COMPUTE: assert reset_n=0 at row 20.
//     -> grid=0, generation=0, busy=0 immediately; a fresh step after release works normally.
//  6. Block still life plus empty grid: 10 steps.
//     -> block unchanged, generation=10; an all-zero grid stays all-zero.

Source files
------------

// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life step engine.
//  - GRID_COLS / GRID_ROWS: default grid size, GRID_CELLS = total cell count
//  - state_t: engine FSM states
//  - cell_idx(c, r): flat bit position of cell (c, r) in a default-sized grid
package life_pkg;

    localparam int GRID_COLS  = 80;
    localparam int GRID_ROWS  = 48;
    localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        WAIT_SYNC,
        COMMIT
    } state_t;

    function automatic int cell_idx(input int c, input int r);
        return c + r * GRID_COLS;
    endfunction

endpackage

// File: rtl/life_row_update.sv
// One row of a B3/S23 generation, purely combinational.
//  above, cur, below : the three grid rows around the row being updated
//  next_row          : new state of the cur row
// Horizontal neighbours wrap around when WRAP=1; otherwise cells beyond the
// left/right edge count as dead. Vertical edge handling is done by the caller,
// which passes an all-zero row for above/below when they fall outside the grid.
module life_row_update
    import life_pkg::*;
#(
    parameter int COLS = GRID_COLS,
    parameter bit WRAP = 1'b1
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] next_row
);

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            // Neighbour column indices and whether they exist, resolved at elaboration.
            localparam int LI   = (gi == 0) ? COLS - 1 : gi - 1;
            localparam int RI   = (gi == COLS - 1) ? 0 : gi + 1;
            localparam bit L_OK = WRAP || (gi != 0);
            localparam bit R_OK = WRAP || (gi != COLS - 1);

            logic [2:0] left_col;
            logic [2:0] right_col;
            logic [3:0] n;

            assign left_col  = L_OK ? {above[LI], cur[LI], below[LI]} : 3'b000;
            assign right_col = R_OK ? {above[RI], cur[RI], below[RI]} : 3'b000;

            assign n = 4'(left_col[0]) + 4'(left_col[1]) + 4'(left_col[2])
                     + 4'(right_col[0]) + 4'(right_col[1]) + 4'(right_col[2])
                     + 4'(above[gi]) + 4'(below[gi]);

            assign next_row[gi] = (n == 4'd3) | (cur[gi] & (n == 4'd2));
        end
    endgenerate

endmodule

// File: rtl/life_step_engine.sv
// Writer side of the cell-grid interface: holds the committed Game-of-Life
// grid, computes the next generation one row per cycle into a shadow buffer,
// and swaps it in atomically on a rising edge of frame_sync.
//  clk, reset_n      : clock, asynchronous active-low reset
//  step              : request one generation (sampled in IDLE only)
//  frame_sync        : vertical sync level; commit happens on its rising edge
//  load_valid/data   : load a seed pattern (sampled in IDLE only, wins over step)
//  grid              : committed generation, bit c + r*COLS is cell (c, r)
//  busy              : high while computing, waiting for sync, or committing
//  done              : one-cycle pulse in the cycle the new grid is visible
//  generation        : committed-generation counter, wraps at 16 bits
module life_step_engine
    import life_pkg::*;
#(
    parameter int COLS = GRID_COLS,
    parameter int ROWS = GRID_ROWS,
    parameter bit WRAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 step,
    input  logic                 frame_sync,
    input  logic                 load_valid,
    input  logic [COLS*ROWS-1:0] load_data,
    output logic [COLS*ROWS-1:0] grid,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          generation
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t                 state;
    logic [ROW_W-1:0]       row;
    logic [COLS-1:0]        shadow [ROWS];
    logic [COLS*ROWS-1:0]   shadow_flat;
    logic                   fs_q;
    logic                   fs_rise;

    logic [ROW_W-1:0]       row_up;
    logic [ROW_W-1:0]       row_dn;
    logic [COLS-1:0]        above;
    logic [COLS-1:0]        cur_row;
    logic [COLS-1:0]        below;
    logic [COLS-1:0]        next_row;

    assign fs_rise = frame_sync & ~fs_q;

    // Neighbour rows of the row being computed. Rows outside the grid read as
    // dead when edges do not wrap.
    always_comb begin
        row_up  = (row == '0) ? ROW_W'(ROWS - 1) : row - ROW_W'(1);
        row_dn  = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
        above   = grid[int'(row_up) * COLS +: COLS];
        cur_row = grid[int'(row) * COLS +: COLS];
        below   = grid[int'(row_dn) * COLS +: COLS];
        if (!WRAP && (row == '0)) begin
            above = '0;
        end
        if (!WRAP && (row == ROW_W'(ROWS - 1))) begin
            below = '0;
        end
    end

    life_row_update #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_row_update (
        .above    (above),
        .cur      (cur_row),
        .below    (below),
        .next_row (next_row)
    );

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_flat
            assign shadow_flat[gi*COLS +: COLS] = shadow[gi];
        end
    endgenerate

    // The swap is registered on the edge that leaves WAIT_SYNC, so during the
    // single COMMIT cycle the new grid, the incremented count and done are all
    // visible together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            row        <= '0;
            grid       <= '0;
            generation <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fs_q       <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            fs_q <= frame_sync;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        grid       <= load_data;
                        generation <= '0;
                    end else if (step) begin
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    shadow[row] <= next_row;
                    if (row == ROW_W'(ROWS - 1)) begin
                        state <= WAIT_SYNC;
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end
                WAIT_SYNC: begin
                    // An edge during the last COMPUTE cycle has already been
                    // absorbed into fs_q, so only a later edge triggers this.
                    if (fs_rise) begin
                        grid       <= shadow_flat;
                        generation <= generation + 16'd1;
                        done       <= 1'b1;
                        state      <= COMMIT;
                    end
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_step_engine.sv
// Self-checking bench for life_step_engine. Two instances share all inputs:
// one with toroidal edges, one with dead edges. A cell-by-cell reference model
// predicts every committed generation.
module tb_life_step_engine;
    import life_pkg::*;

    localparam int C = GRID_COLS;
    localparam int R = GRID_ROWS;
    localparam int N = GRID_CELLS;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         step = 1'b0;
    logic         frame_sync = 1'b0;
    logic         load_valid = 1'b0;
    logic [N-1:0] load_data = '0;

    logic [N-1:0] grid_w, grid_n;
    logic         busy_w, busy_n, done_w, done_n;
    logic [15:0]  gen_w, gen_n;

    logic [N-1:0] exp_w, exp_n, pat, other;
    int           exp_gen;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    life_step_engine #(.COLS(C), .ROWS(R), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset_n(reset_n), .step(step), .frame_sync(frame_sync),
        .load_valid(load_valid), .load_data(load_data),
        .grid(grid_w), .busy(busy_w), .done(done_w), .generation(gen_w)
    );

    life_step_engine #(.COLS(C), .ROWS(R), .WRAP(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .step(step), .frame_sync(frame_sync),
        .load_valid(load_valid), .load_data(load_data),
        .grid(grid_n), .busy(busy_n), .done(done_n), .generation(gen_n)
    );

    // Reference: count the eight neighbours of every cell directly.
    function automatic logic [N-1:0] life_next(input logic [N-1:0] g, input bit wrap);
        logic [N-1:0] nx;
        nx = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + R) % R;
                            cc = (cc + C) % C;
                        end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
                            continue;
                        end
                        n += int'(g[cell_idx(cc, rr)]);
                    end
                end
                nx[cell_idx(c, r)] = (n == 3) || (g[cell_idx(c, r)] && n == 2);
            end
        end
        return nx;
    endfunction

    function automatic logic [N-1:0] rand_grid();
        logic [N-1:0] g;
        for (int i = 0; i < N; i++) g[i] = ($urandom_range(0, 2) == 0);
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_grid(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        int first;
        checks++;
        assert (obs === exp) else begin
            failures++;
            first = -1;
            for (int i = 0; i < N; i++) begin
                if (first < 0 && obs[i] !== exp[i]) first = i;
            end
            $error("FAIL %s: observed live=%0d expected live=%0d first_diff_bit=%0d (col %0d row %0d)",
                   tag, $countones(obs), $countones(exp), first, first % C, first / C);
        end
    endtask

    task automatic chk_state(input string tag, input logic busy_exp, input logic done_exp);
        chk_grid({tag, " grid_w"}, grid_w, exp_w);
        chk_grid({tag, " grid_n"}, grid_n, exp_n);
        chk16({tag, " gen_w"}, gen_w, 16'(exp_gen));
        chk16({tag, " gen_n"}, gen_n, 16'(exp_gen));
        chk_bit({tag, " busy_w"}, busy_w, busy_exp);
        chk_bit({tag, " busy_n"}, busy_n, busy_exp);
        chk_bit({tag, " done_w"}, done_w, done_exp);
        chk_bit({tag, " done_n"}, done_n, done_exp);
    endtask

    task automatic do_load(input string tag, input logic [N-1:0] p);
        load_valid = 1'b1;
        load_data  = p;
        tick();
        load_valid = 1'b0;
        exp_w = p;
        exp_n = p;
        exp_gen = 0;
        chk_state({tag, " load"}, 1'b0, 1'b0);
        $display("load %s live=%0d", tag, $countones(p));
    endtask

    // One generation: step, hold frame_sync low for R + hold cycles, then raise it.
    task automatic do_gen(input string tag, input int hold);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk_state({tag, " compute"}, 1'b1, 1'b0);
        for (int i = 0; i < R + hold; i++) begin
            tick();
            chk_state({tag, " waiting"}, 1'b1, 1'b0);
        end
        frame_sync = 1'b1;
        tick();
        exp_w = life_next(exp_w, 1'b1);
        exp_n = life_next(exp_n, 1'b0);
        exp_gen = (exp_gen + 1) % 65536;
        chk_state({tag, " commit"}, 1'b1, 1'b1);
        frame_sync = 1'b0;
        tick();
        chk_state({tag, " idle"}, 1'b0, 1'b0);
        $display("gen %s count=%0d live_w=%0d live_n=%0d", tag, exp_gen,
                 $countones(exp_w), $countones(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_w = '0;
        exp_n = '0;
        exp_gen = 0;

        // Reset state
        repeat (3) tick();
        chk_state("reset", 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        chk_state("post_reset", 1'b0, 1'b0);

        // Blinker
        pat = '0;
        pat[cell_idx(10, 9)] = 1'b1;
        pat[cell_idx(10, 10)] = 1'b1;
        pat[cell_idx(10, 11)] = 1'b1;
        do_load("blinker", pat);
        do_gen("blinker", 0);
        other = '0;
        other[cell_idx(9, 10)] = 1'b1;
        other[cell_idx(10, 10)] = 1'b1;
        other[cell_idx(11, 10)] = 1'b1;
        chk_grid("blinker horizontal", grid_w, other);
        chk16("blinker gen", gen_w, 16'd1);

        // Glider across the corner
        pat = '0;
        pat[cell_idx(79, 46)] = 1'b1;
        pat[cell_idx(0, 47)] = 1'b1;
        pat[cell_idx(78, 0)] = 1'b1;
        pat[cell_idx(79, 0)] = 1'b1;
        pat[cell_idx(0, 0)] = 1'b1;
        do_load("glider", pat);
        for (int g = 0; g < 4; g++) do_gen("glider", $urandom_range(0, 3));
        other = '0;
        other[cell_idx(0, 47)] = 1'b1;
        other[cell_idx(1, 0)] = 1'b1;
        other[cell_idx(79, 1)] = 1'b1;
        other[cell_idx(0, 1)] = 1'b1;
        other[cell_idx(1, 1)] = 1'b1;
        chk_grid("glider shifted", grid_w, other);

        // Sync gating: long hold with frame_sync low
        do_load("sync_gate", rand_grid());
        do_gen("sync_gate", 200 - R);

        // frame_sync edge during the last COMPUTE cycle is not seen
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (R - 1) tick();
        frame_sync = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("late_edge held", 1'b1, 1'b0);
        end
        frame_sync = 1'b0;
        tick();
        chk_state("late_edge low", 1'b1, 1'b0);
        frame_sync = 1'b1;
        tick();
        exp_w = life_next(exp_w, 1'b1);
        exp_n = life_next(exp_n, 1'b0);
        exp_gen++;
        chk_state("late_edge commit", 1'b1, 1'b1);
        frame_sync = 1'b0;
        tick();
        chk_state("late_edge idle", 1'b0, 1'b0);
        $display("gen late_edge count=%0d", exp_gen);

        // Step and load during COMPUTE are ignored
        do_load("ignore", rand_grid());
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (5) tick();
        step = 1'b1;
        load_valid = 1'b1;
        load_data = rand_grid();
        tick();
        step = 1'b0;
        load_valid = 1'b0;
        chk_state("ignore during compute", 1'b1, 1'b0);
        repeat (R) tick();
        frame_sync = 1'b1;
        tick();
        exp_w = life_next(exp_w, 1'b1);
        exp_n = life_next(exp_n, 1'b0);
        exp_gen++;
        chk_state("ignore commit", 1'b1, 1'b1);
        frame_sync = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_state("ignore no_requeue", 1'b0, 1'b0);
        end
        $display("gen ignore count=%0d", exp_gen);

        // Load and step together: the load wins
        pat = rand_grid();
        load_valid = 1'b1;
        step = 1'b1;
        load_data = pat;
        tick();
        load_valid = 1'b0;
        step = 1'b0;
        exp_w = pat;
        exp_n = pat;
        exp_gen = 0;
        chk_state("load_step", 1'b0, 1'b0);
        tick();
        chk_state("load_step after", 1'b0, 1'b0);

        // Reset during COMPUTE at row 20
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (20) tick();
        reset_n = 1'b0;
        #1;
        exp_w = '0;
        exp_n = '0;
        exp_gen = 0;
        chk_state("mid_reset", 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        chk_state("mid_reset released", 1'b0, 1'b0);
        do_gen("after_reset_empty", 0);
        do_load("after_reset", rand_grid());
        do_gen("after_reset", 1);

        // Random soups
        for (int k = 0; k < 2; k++) begin
            do_load("random", rand_grid());
            for (int g = 0; g < 3; g++) do_gen("random", $urandom_range(0, 6));
        end

        // Block still life for 10 generations
        pat = '0;
        pat[cell_idx(30, 20)] = 1'b1;
        pat[cell_idx(31, 20)] = 1'b1;
        pat[cell_idx(30, 21)] = 1'b1;
        pat[cell_idx(31, 21)] = 1'b1;
        do_load("block", pat);
        for (int g = 0; g < 10; g++) do_gen("block", $urandom_range(0, 2));
        chk_grid("block unchanged", grid_w, pat);
        chk16("block gen", gen_w, 16'd10);

        // Empty grid stays empty
        pat = '0;
        do_load("empty", pat);
        do_gen("empty", 0);
        chk_grid("empty stays", grid_w, pat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
